// File: rtl/bias_mode_scheduler_if.sv
// Requester-side request/acknowledge bus of the bias mode scheduler.
interface bias_mode_scheduler_if;
    logic [2:0] req_valid;
    logic [5:0] req_mode;
    logic [2:0] req_ack;
    logic       ack_err;

    // Requesters drive valid/mode and observe the ack.
    modport master (
        output req_valid,
        output req_mode,
        input  req_ack,
        input  ack_err
    );

    // The scheduler consumes requests and returns the ack.
    modport slave (
        input  req_valid,
        input  req_mode,
        output req_ack,
        output ack_err
    );
endinterface

// File: rtl/bias_mode_scheduler.sv
// Arbitrates bias-mode requests and sequences the bias mux through each change,
// with busy/ready tracking, post-change dwell and settle-timeout fallback to SLEEP.
module bias_mode_scheduler #(
    parameter logic [1:0]  RESET_MODE       = 2'b00,
    parameter int unsigned BUSY_WAIT_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 5000,
    parameter int unsigned DWELL_CYCLES     = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bias_mode_scheduler_if.slave  req,
    output logic [1:0]            bias_mode_select,
    input  logic                  bias_busy,
    input  logic                  bias_ready,
    output logic [1:0]            current_mode,
    output logic                  sched_busy,
    output logic                  timeout_flag,
    input  logic                  clear_fault
);

    localparam int unsigned BW = $clog2(BUSY_WAIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

    localparam logic [BW-1:0] BUSY_LIM  = BW'(BUSY_WAIT_CYCLES);
    localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DWELL_LIM = DW'(DWELL_CYCLES);

    localparam logic [1:0] MODE_SLEEP = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_READY,
        S_DWELL,
        S_FAULT
    } state_t;

    state_t        state;
    logic [1:0]    gnt_idx;
    logic [1:0]    gnt_mode;
    logic [BW-1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] dcnt;

    logic [2:0]    cand_c;
    logic          arb_hit_c;
    logic [1:0]    arb_idx_c;
    logic [1:0]    arb_mode_c;
    logic [BW-1:0] bcnt_inc_c;
    logic [TW-1:0] tcnt_inc_c;
    logic          busy_hit_c;
    logic          to_hit_c;

    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    idx_onehot = 3'b001;
            2'd1:    idx_onehot = 3'b010;
            default: idx_onehot = 3'b100;
        endcase
    endfunction

    // A requester whose ack is on the bus this cycle has not yet dropped valid; mask it.
    assign cand_c = req.req_valid & ~req.req_ack;

    // Fixed-priority arbitration, lowest index wins.
    always_comb begin
        arb_hit_c = 1'b1;
        arb_idx_c = 2'd0;
        if (cand_c[0]) begin
            arb_idx_c = 2'd0;
        end else if (cand_c[1]) begin
            arb_idx_c = 2'd1;
        end else if (cand_c[2]) begin
            arb_idx_c = 2'd2;
        end else begin
            arb_hit_c = 1'b0;
        end
        case (arb_idx_c)
            2'd0:    arb_mode_c = req.req_mode[1:0];
            2'd1:    arb_mode_c = req.req_mode[3:2];
            default: arb_mode_c = req.req_mode[5:4];
        endcase
    end

    // Saturating counter increments and their terminal conditions.
    assign bcnt_inc_c = (bcnt == BUSY_LIM) ? bcnt : bcnt + BW'(1);
    assign tcnt_inc_c = (tcnt == TO_LIM)   ? tcnt : tcnt + TW'(1);
    assign busy_hit_c = (bcnt_inc_c == BUSY_LIM);
    assign to_hit_c   = (tcnt_inc_c == TO_LIM);

    // Scheduler FSM with registered outputs; acks are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            bias_mode_select <= RESET_MODE;
            current_mode     <= RESET_MODE;
            req.req_ack      <= 3'b000;
            req.ack_err      <= 1'b0;
            sched_busy       <= 1'b0;
            timeout_flag     <= 1'b0;
            gnt_idx          <= 2'd0;
            gnt_mode         <= RESET_MODE;
            bcnt             <= '0;
            tcnt             <= '0;
            dcnt             <= '0;
        end else begin
            req.req_ack <= 3'b000;
            req.ack_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arb_hit_c) begin
                        gnt_idx  <= arb_idx_c;
                        gnt_mode <= arb_mode_c;
                        if (arb_mode_c == MODE_RSVD) begin
                            req.req_ack <= idx_onehot(arb_idx_c);
                            req.ack_err <= 1'b1;
                        end else if (arb_mode_c == current_mode) begin
                            req.req_ack <= idx_onehot(arb_idx_c);
                        end else begin
                            bias_mode_select <= arb_mode_c;
                            bcnt             <= '0;
                            tcnt             <= '0;
                            state            <= S_WAIT_BUSY;
                            sched_busy       <= 1'b1;
                        end
                    end
                end
                S_WAIT_BUSY, S_WAIT_READY: begin
                    tcnt <= tcnt_inc_c;
                    if (to_hit_c) begin
                        bias_mode_select <= MODE_SLEEP;
                        current_mode     <= MODE_SLEEP;
                        req.req_ack      <= idx_onehot(gnt_idx);
                        req.ack_err      <= 1'b1;
                        timeout_flag     <= 1'b1;
                        state            <= S_FAULT;
                    end else if (state == S_WAIT_BUSY) begin
                        bcnt <= bcnt_inc_c;
                        if (bias_busy || busy_hit_c) begin
                            state <= S_WAIT_READY;
                        end
                    end else if (!bias_busy && bias_ready) begin
                        current_mode <= gnt_mode;
                        req.req_ack  <= idx_onehot(gnt_idx);
                        dcnt         <= DWELL_LIM;
                        state        <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (dcnt <= DW'(1)) begin
                        dcnt       <= '0;
                        state      <= S_IDLE;
                        sched_busy <= 1'b0;
                    end else begin
                        dcnt <= dcnt - DW'(1);
                    end
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        timeout_flag <= 1'b0;
                        state        <= S_IDLE;
                        sched_busy   <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_mode_scheduler.sv
// Directed bench for bias_mode_scheduler: vector table plus multi-cycle sequences.
module tb_bias_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] bias_mode_select;
    logic       bias_busy;
    logic       bias_ready;
    logic [1:0] current_mode;
    logic       sched_busy;
    logic       timeout_flag;
    logic       clear_fault;

    bias_mode_scheduler_if bus ();

    bias_mode_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (bus),
        .bias_mode_select (bias_mode_select),
        .bias_busy        (bias_busy),
        .bias_ready       (bias_ready),
        .current_mode     (current_mode),
        .sched_busy       (sched_busy),
        .timeout_flag     (timeout_flag),
        .clear_fault      (clear_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int viol = 0;
    int ack_pulses = 0;

    bit         hang = 1'b0;
    int         mux_cnt = 0;
    logic [1:0] mux_last = 2'b00;

    typedef struct {
        logic [2:0] valid;
        logic [5:0] modes;
        logic [2:0] exp_ack;
        logic       exp_err;
        logic [1:0] exp_cur;
        bit         exp_dwell;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output int cycles);
        cycles = 0;
        while (bus.req_ack == 3'b000 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (sched_busy && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    // Mux model: busy for 3 cycles after each new select, then ready; hang holds busy.
    initial begin
        bias_busy  = 1'b0;
        bias_ready = 1'b1;
        forever begin
            tick();
            if (!rst_n) begin
                bias_busy  = 1'b0;
                bias_ready = 1'b1;
                mux_cnt    = 0;
                mux_last   = bias_mode_select;
            end else if (hang) begin
                bias_busy  = 1'b1;
                bias_ready = 1'b0;
                mux_cnt    = 0;
                mux_last   = bias_mode_select;
            end else if (bias_mode_select != mux_last) begin
                mux_last   = bias_mode_select;
                mux_cnt    = 3;
                bias_busy  = 1'b1;
                bias_ready = 1'b0;
            end else if (mux_cnt > 0) begin
                mux_cnt--;
                if (mux_cnt == 0) begin
                    bias_busy  = 1'b0;
                    bias_ready = 1'b1;
                end
            end else begin
                bias_busy  = 1'b0;
                bias_ready = 1'b1;
            end
        end
    end

    // Protocol monitor: one-hot ack, ack_err only alongside ack, pulse count.
    always @(negedge clk) begin
        if ($countones(bus.req_ack) > 1 || (bus.req_ack == 3'b000 && bus.ack_err)) viol++;
        if (bus.req_ack != 3'b000) ack_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        int acks;
        int pulses0;

        vecs[0] = '{3'b010, 6'b00_01_00, 3'b010, 1'b0, 2'b01, 1'b1};
        vecs[1] = '{3'b100, 6'b01_00_00, 3'b100, 1'b0, 2'b01, 1'b0};
        vecs[2] = '{3'b001, 6'b00_00_11, 3'b001, 1'b1, 2'b01, 1'b0};
        vecs[3] = '{3'b001, 6'b00_00_10, 3'b001, 1'b0, 2'b10, 1'b1};
        vecs[4] = '{3'b100, 6'b00_00_00, 3'b100, 1'b0, 2'b00, 1'b1};
        vecs[5] = '{3'b010, 6'b00_00_00, 3'b010, 1'b0, 2'b00, 1'b0};
        vecs[6] = '{3'b100, 6'b11_00_00, 3'b100, 1'b1, 2'b00, 1'b0};

        rst_n         = 1'b0;
        clear_fault   = 1'b0;
        bus.req_valid = 3'b000;
        bus.req_mode  = 6'b000000;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_sel",   32'(bias_mode_select), 32'h0);
        check("rst_cur",   32'(current_mode),     32'h0);
        check("rst_ack",   32'(bus.req_ack),      32'h0);
        check("rst_err",   32'(bus.ack_err),      32'h0);
        check("rst_busy",  32'(sched_busy),       32'h0);
        check("rst_flag",  32'(timeout_flag),     32'h0);

        // Single-request vectors.
        for (int i = 0; i < 7; i++) begin
            bus.req_valid = vecs[i].valid;
            bus.req_mode  = vecs[i].modes;
            tick();
            if (vecs[i].exp_dwell) begin
                check($sformatf("v%0d_grant_sel", i), 32'(bias_mode_select), 32'(vecs[i].exp_cur));
                check($sformatf("v%0d_grant_busy", i), 32'(sched_busy), 32'h1);
                wait_ack(6000, n);
            end
            check($sformatf("v%0d_ack", i), 32'(bus.req_ack), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_err", i), 32'(bus.ack_err), 32'(vecs[i].exp_err));
            bus.req_valid = 3'b000;
            check($sformatf("v%0d_cur", i), 32'(current_mode), 32'(vecs[i].exp_cur));
            check($sformatf("v%0d_sel", i), 32'(bias_mode_select), 32'(vecs[i].exp_cur));
            if (vecs[i].exp_dwell) begin
                check($sformatf("v%0d_dwell_busy", i), 32'(sched_busy), 32'h1);
                wait_idle(1100, n2);
                check($sformatf("v%0d_dwell_len", i), 32'(n2), 32'd1000);
            end else begin
                check($sformatf("v%0d_no_dwell", i), 32'(sched_busy), 32'h0);
                tick();
                check($sformatf("v%0d_ack_single", i), 32'(bus.req_ack), 32'h0);
            end
        end

        // Priority: req0 and req2 together; req2 waits out the dwell, no preemption by req0.
        bus.req_valid = 3'b101;
        bus.req_mode  = 6'b01_00_10;
        tick();
        check("prio_sel0", 32'(bias_mode_select), 32'h2);
        wait_ack(6000, n);
        check("prio_ack0", 32'(bus.req_ack), 32'h1);
        check("prio_cur0", 32'(current_mode), 32'h2);
        bus.req_valid = 3'b100;
        n = 0;
        while (bias_mode_select != 2'b01 && n < 1200) begin
            tick();
            n++;
        end
        check("prio_gap", 32'(n), 32'd1001);
        bus.req_valid = 3'b001;
        bus.req_mode  = 6'b01_00_00;
        wait_ack(6000, n);
        check("prio_ack2", 32'(bus.req_ack), 32'h4);
        check("prio_err2", 32'(bus.ack_err), 32'h0);
        check("prio_cur2", 32'(current_mode), 32'h1);
        tick();
        wait_ack(1200, n);
        check("prio_ack0b", 32'(bus.req_ack), 32'h1);
        check("prio_cur0b", 32'(current_mode), 32'h0);
        bus.req_valid = 3'b000;
        wait_idle(1100, n2);
        check("prio_dwell", 32'(n2), 32'd1000);

        // Settle timeout: fault to SLEEP, pending request held until clear_fault.
        hang          = 1'b1;
        bus.req_valid = 3'b010;
        bus.req_mode  = 6'b00_01_00;
        tick();
        check("to_grant_sel", 32'(bias_mode_select), 32'h1);
        bus.req_valid = 3'b110;
        bus.req_mode  = 6'b01_01_00;
        wait_ack(5100, n);
        check("to_latency", 32'(n), 32'd5000);
        check("to_ack", 32'(bus.req_ack), 32'h2);
        check("to_err", 32'(bus.ack_err), 32'h1);
        check("to_sel", 32'(bias_mode_select), 32'h2);
        check("to_cur", 32'(current_mode), 32'h2);
        check("to_flag", 32'(timeout_flag), 32'h1);
        bus.req_valid = 3'b100;
        hang = 1'b0;
        acks = 0;
        repeat (50) begin
            tick();
            if (bus.req_ack != 3'b000) acks++;
        end
        check("fault_no_ack", 32'(acks), 32'h0);
        check("fault_busy", 32'(sched_busy), 32'h1);
        check("fault_sel", 32'(bias_mode_select), 32'h2);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("clr_flag", 32'(timeout_flag), 32'h0);
        check("clr_idle", 32'(sched_busy), 32'h0);
        tick();
        check("clr_grant_sel", 32'(bias_mode_select), 32'h1);
        wait_ack(6000, n);
        check("clr_ack", 32'(bus.req_ack), 32'h4);
        check("clr_err", 32'(bus.ack_err), 32'h0);
        check("clr_cur", 32'(current_mode), 32'h1);
        bus.req_valid = 3'b000;
        wait_idle(1100, n2);
        check("clr_dwell", 32'(n2), 32'd1000);

        // Asynchronous reset while waiting for ready: no ack for the aborted request.
        hang          = 1'b1;
        bus.req_valid = 3'b001;
        bus.req_mode  = 6'b00_00_10;
        tick();
        check("ar_grant_sel", 32'(bias_mode_select), 32'h2);
        repeat (10) tick();
        pulses0 = ack_pulses;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_sel",  32'(bias_mode_select), 32'h0);
        check("ar_cur",  32'(current_mode),     32'h0);
        check("ar_busy", 32'(sched_busy),       32'h0);
        check("ar_ack",  32'(bus.req_ack),      32'h0);
        check("ar_flag", 32'(timeout_flag),     32'h0);
        bus.req_valid = 3'b000;
        hang = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("ar_no_pulse", 32'(ack_pulses - pulses0), 32'h0);
        check("ar_idle", 32'(sched_busy), 32'h0);

        check("ack_protocol", 32'(viol), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
